// File: rtl/regseq_pkg.sv
// Shared op codes and sequencer state encodings.
// Imported by regseq_alu and regfile_sequencer.
package regseq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ_A = 3'd1,
      S_READ_B = 3'd2,
      S_EXEC   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5
   } state_e;

endpackage

// File: rtl/regseq_alu.sv
// Combinational op decode and arithmetic for the register-file sequencer.
// Results wrap modulo 2^p_data_width; no carry or borrow is kept.
module regseq_alu
   import regseq_pkg::*;
#(
   parameter int p_data_width = 5
) (
   input  logic [p_data_width-1:0] a,
   input  logic [p_data_width-1:0] b,
   input  op_e                     op,
   output logic [p_data_width-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_XOR:  y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Reads two registers, applies an ALU op and writes the result back.
// Optional macro REGSEQ_SAME_SRC_SKIP_EN skips READ_B when rs == rt.
module regfile_sequencer
   import regseq_pkg::*;
#(
   parameter int p_data_width    = 5,
   parameter int p_address_width = 3
) (
   input  logic                       i_w_clk,
   input  logic                       i_w_reset,
   input  logic                       i_w_start,
   input  logic [1:0]                 i_w_op,
   input  logic [p_address_width-1:0] i_w_rs,
   input  logic [p_address_width-1:0] i_w_rt,
   input  logic [p_address_width-1:0] i_w_rd,
   output logic [p_address_width-1:0] o_w_reg,
   output logic                       o_w_oe,
   output logic                       o_w_we,
   output logic [p_data_width-1:0]    o_w_wdata,
   input  logic [p_data_width-1:0]    i_w_rdata,
   output logic                       o_w_busy,
   output logic                       o_w_done,
   output logic [p_data_width-1:0]    o_w_result
);

   state_e                     state_q;
   state_e                     state_d;
   op_e                        op_q;
   logic [p_address_width-1:0] rs_q;
   logic [p_address_width-1:0] rt_q;
   logic [p_address_width-1:0] rd_q;
   logic [p_data_width-1:0]    a_q;
   logic [p_data_width-1:0]    b_q;
   logic [p_data_width-1:0]    res_q;
   logic [p_data_width-1:0]    result_q;
   logic [p_data_width-1:0]    alu_y;

   regseq_alu #(
      .p_data_width(p_data_width)
   ) u_alu (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .y  (alu_y)
   );

   always_ff @(posedge i_w_clk or negedge i_w_reset) begin
      if (!i_w_reset) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (i_w_start) begin
                  op_q <= op_e'(i_w_op);
                  rs_q <= i_w_rs;
                  rt_q <= i_w_rt;
                  rd_q <= i_w_rd;
               end
            end
            S_READ_A: begin
               a_q <= i_w_rdata;
`ifdef REGSEQ_SAME_SRC_SKIP_EN
               if (rs_q == rt_q) b_q <= i_w_rdata;
`endif
            end
            S_READ_B: b_q <= i_w_rdata;
            S_EXEC:   res_q <= alu_y;
            // result only becomes visible once the write has committed
            S_WRITE:  result_q <= res_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      o_w_reg   = '0;
      o_w_oe    = 1'b0;
      o_w_we    = 1'b0;
      o_w_wdata = '0;
      unique case (state_q)
         S_IDLE: begin
            if (i_w_start) state_d = S_READ_A;
         end
         S_READ_A: begin
            o_w_reg = rs_q;
            o_w_oe  = 1'b1;
            state_d = S_READ_B;
`ifdef REGSEQ_SAME_SRC_SKIP_EN
            if (rs_q == rt_q) state_d = S_EXEC;
`endif
         end
         S_READ_B: begin
            o_w_reg = rt_q;
            o_w_oe  = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: state_d = S_WRITE;
         S_WRITE: begin
            o_w_reg   = rd_q;
            o_w_we    = 1'b1;
            o_w_wdata = res_q;
            state_d   = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign o_w_busy   = (state_q != S_IDLE);
   assign o_w_done   = (state_q == S_DONE);
   assign o_w_result = result_q;

endmodule
